// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter for the ALU result path.
// Double-dabble, one bit per cycle, with a start/busy/done handshake.
module result_bcd_converter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      result,
  input  logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   shreg, shreg_n;
  logic [BCD_W-1:0]   scratch, scratch_n;
  logic [CNT_W-1:0]   count, count_n;
  logic               sign_lat, sign_lat_n;
  logic [BCD_W-1:0]   bcd_n;
  logic               sign_n, busy_n, done_n;

  logic [WIDTH-1:0]       mag;
  logic [BCD_W-1:0]       adj;
  logic [BCD_W+WIDTH-1:0] shifted;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      scratch  <= '0;
      count    <= '0;
      sign_lat <= 1'b0;
      bcd      <= '0;
      sign     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      scratch  <= scratch_n;
      count    <= count_n;
      sign_lat <= sign_lat_n;
      bcd      <= bcd_n;
      sign     <= sign_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    scratch_n  = scratch;
    count_n    = count;
    sign_lat_n = sign_lat;
    bcd_n      = bcd;
    sign_n     = sign;
    busy_n     = busy;
    done_n     = 1'b0;

    mag = neg ? WIDTH'(~result + WIDTH'(1)) : result;

    // Add-3 correction keeps every digit decimal after the doubling shift
    adj = scratch;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (adj[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end
    end
    shifted = {adj, shreg} << 1;

    case (state)
      IDLE: begin
        if (start) begin
          shreg_n    = mag;
          sign_lat_n = neg & (mag != '0);
          scratch_n  = '0;
          count_n    = '0;
          busy_n     = 1'b1;
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_n = shifted[BCD_W+WIDTH-1:WIDTH];
        shreg_n   = shifted[WIDTH-1:0];
        count_n   = count + CNT_W'(1);
        if (count == CNT_W'(WIDTH - 1)) begin
          bcd_n   = shifted[BCD_W+WIDTH-1:WIDTH];
          sign_n  = sign_lat;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed self-checking bench for result_bcd_converter.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] result;
  logic        neg;
  logic [19:0] bcd;
  logic        sign, busy, done;

  int passed = 0;
  int total  = 0;

  result_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .result(result), .neg(neg),
    .bcd(bcd), .sign(sign), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Wait for done; optionally re-pulse start with a new operand mid-conversion.
  task automatic wait_done(input int repulse_cyc, input logic [15:0] rp_res,
                           output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == repulse_cyc) begin
        start  = 1'b1;
        result = rp_res;
        neg    = 1'b1;
      end else if (repulse_cyc != 0 && c == repulse_cyc + 1) begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (done) begin
        lat = c - 1;
        break;
      end
    end
  endtask

  task automatic do_conv(input string tag, input logic [15:0] res, input logic n,
                         input logic [19:0] exp_bcd, input logic exp_sign);
    int lat, bcnt;
    result = res;
    neg    = n;
    start  = 1'b1;
    wait_done(0, 16'h0, lat, bcnt);
    chk({tag, "_latency"}, 32'(lat), 32'd16);
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd16);
    chk({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    chk({tag, "_sign"}, 32'(sign), 32'(exp_sign));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_bcd_held"}, 32'(bcd), 32'(exp_bcd));
  endtask

  initial begin
    int lat, bcnt;
    rst_n  = 1'b0;
    start  = 1'b0;
    result = 16'h0;
    neg    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_sign", 32'(sign), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_conv("t1_00ff", 16'h00FF, 1'b0, 20'h00255, 1'b0);
    do_conv("t2_neg2", 16'hFFFE, 1'b1, 20'h00002, 1'b1);
    do_conv("t3_max", 16'hFFFF, 1'b0, 20'h65535, 1'b0);
    do_conv("t3_minneg", 16'h8000, 1'b1, 20'h32768, 1'b1);
    do_conv("t4_negzero", 16'h0000, 1'b1, 20'h00000, 1'b0);
    do_conv("t_9999", 16'd9999, 1'b0, 20'h09999, 1'b0);
    do_conv("t_neg10", 16'hFFF6, 1'b1, 20'h00010, 1'b1);

    // Start re-pulsed mid-conversion is ignored; start in done cycle is accepted
    result = 16'd500;
    neg    = 1'b0;
    start  = 1'b1;
    wait_done(5, 16'd777, lat, bcnt);
    chk("t5_first_latency", 32'(lat), 32'd16);
    chk("t5_first_bcd", 32'(bcd), 32'h00500);
    chk("t5_first_sign", 32'(sign), 32'h0);
    result = 16'd1234;
    neg    = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_chain_busy", 32'(busy), 32'h1);
    chk("t5_chain_bcd_held", 32'(bcd), 32'h00500);
    wait_done(0, 16'h0, lat, bcnt);
    chk("t5_second_latency", 32'(lat), 32'd15);
    chk("t5_second_bcd", 32'(bcd), 32'h01234);

    // Reset asserted mid-conversion aborts without a done pulse
    @(negedge clk);
    result = 16'd4321;
    neg    = 1'b1;
    start  = 1'b1;
    repeat (8) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("t6_busy_before_rst", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bcd", 32'(bcd), 32'h0);
    chk("t6_rst_sign", 32'(sign), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) bcnt++;
    end
    chk("t6_no_done_after_abort", 32'(bcnt), 32'd0);
    do_conv("t6_after_42", 16'd42, 1'b0, 20'h00042, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
